// File: rtl/rep_arb_if.sv
// Bundle of requester and output-stream signals for the shared byte-replication datapath.
// The arbiter takes the slave side and the producers/consumer take the master side.
interface rep_arb_if #(
  parameter int DW    = 8,
  parameter int REP   = 4,
  parameter int CNT_W = 4
);
  logic                req0_valid;
  logic [DW-1:0]       req0_data;
  logic [CNT_W-1:0]    req0_len;
  logic                req0_ready;
  logic                req1_valid;
  logic [DW-1:0]       req1_data;
  logic [CNT_W-1:0]    req1_len;
  logic                req1_ready;
  logic                out_valid;
  logic [DW*REP-1:0]   out_data;
  logic                out_src;
  logic                out_last;
  logic                out_ready;
  logic                busy;

  modport slave (
    input  req0_valid, req0_data, req0_len,
    input  req1_valid, req1_data, req1_len,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_src, out_last, busy
  );

  modport master (
    output req0_valid, req0_data, req0_len,
    output req1_valid, req1_data, req1_len,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_src, out_last, busy
  );
endinterface

// File: rtl/rep_arb_ctrl.sv
// Round-robin arbiter that grants one of two byte requesters and streams the
// winner's byte, replicated REP times, for the requested number of beats.
module rep_arb_ctrl #(
  parameter int DW    = 8,
  parameter int REP   = 4,
  parameter int CNT_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  rep_arb_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic                ptr_r, ptr_s;
  logic [CNT_W-1:0]    rem_r, rem_s;
  logic                out_valid_r, out_valid_s;
  logic [DW*REP-1:0]   out_data_r, out_data_s;
  logic                out_src_r, out_src_s;
  logic                out_last_r, out_last_s;
  logic                busy_r, busy_s;
  logic                grant0_s, grant1_s;
  logic [DW-1:0]       sel_data_s;
  logic [CNT_W-1:0]    sel_len_s;

  function automatic logic [DW*REP-1:0] rep_word(input logic [DW-1:0] b);
    rep_word = {REP{b}};
  endfunction

  // Grant selection, next-state and next-output computation.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    rem_s       = rem_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    out_src_s   = out_src_r;
    out_last_s  = out_last_r;
    busy_s      = busy_r;
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    sel_data_s  = bus.req0_data;
    sel_len_s   = bus.req0_len;
    case (state_r)
      IDLE: begin
        // ptr_r == 0 favours req0 when both are valid
        if (bus.req0_valid && (!bus.req1_valid || !ptr_r)) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = bus.req1_valid;
        end
        if (grant1_s) begin
          sel_data_s = bus.req1_data;
          sel_len_s  = bus.req1_len;
        end else begin
          sel_data_s = bus.req0_data;
          sel_len_s  = bus.req0_len;
        end
        if (grant0_s || grant1_s) begin
          ptr_s      = ~grant1_s;
          rem_s      = sel_len_s;
          out_src_s  = grant1_s;
          out_data_s = rep_word(sel_data_s);
          if (sel_len_s != '0) begin
            state_s     = STREAM;
            out_valid_s = 1'b1;
            busy_s      = 1'b1;
            out_last_s  = (sel_len_s == CNT_W'(1));
          end else begin
            state_s     = IDLE;
            out_valid_s = 1'b0;
            busy_s      = 1'b0;
            out_last_s  = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          rem_s = rem_r - CNT_W'(1);
          if (out_last_r) begin
            state_s     = IDLE;
            out_valid_s = 1'b0;
            busy_s      = 1'b0;
            out_last_s  = 1'b0;
          end else begin
            out_last_s = (rem_r == CNT_W'(2));
          end
        end else begin
          rem_s = rem_r;
        end
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        out_last_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset aborts any burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      rem_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      rem_r       <= rem_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_src_r   <= out_src_s;
      out_last_r  <= out_last_s;
      busy_r      <= busy_s;
    end
  end

  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_src    = out_src_r;
  assign bus.out_last   = out_last_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_rep_arb_ctrl.sv
// Self-checking bench for rep_arb_ctrl: directed scenarios followed by random
// traffic, all checked against a queue-based model of the expected beat stream.
module tb_rep_arb_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        src;
    logic        last;
  } beat_t;

  logic  clk;
  logic  rst_n;
  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;
  int    acc0   = 0;
  int    acc1   = 0;
  logic  mptr   = 1'b0;
  beat_t q[$];

  rep_arb_if #(.DW(8), .REP(4), .CNT_W(4)) bus ();

  rep_arb_ctrl #(.DW(8), .REP(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check DUT against the model just before the edge, then advance both.
  task automatic cycle();
    logic  idle, e0, e1;
    beat_t b;
    int    len;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      @(posedge clk);
      #1;
      q.delete();
      mptr = 1'b0;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy",      {31'd0, bus.busy},      32'd0);
      chk("rst_out_data",  bus.out_data,           32'd0);
      chk("rst_out_src",   {31'd0, bus.out_src},   32'd0);
      chk("rst_out_last",  {31'd0, bus.out_last},  32'd0);
      return;
    end
    idle = (q.size() == 0);
    e0 = idle && bus.req0_valid && (!bus.req1_valid || (mptr == 1'b0));
    e1 = idle && bus.req1_valid && !e0;
    chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e1});
    chk("out_valid",  {31'd0, bus.out_valid},  {31'd0, !idle});
    chk("busy",       {31'd0, bus.busy},       {31'd0, !idle});
    if (!idle) begin
      b = q[0];
      chk("out_data", bus.out_data,           b.data);
      chk("out_src",  {31'd0, bus.out_src},   {31'd0, b.src});
      chk("out_last", {31'd0, bus.out_last},  {31'd0, b.last});
      if (bus.out_ready) begin
        b = q.pop_front();
        beats++;
      end
    end else if (e0 || e1) begin
      len    = e1 ? int'(bus.req1_len) : int'(bus.req0_len);
      b.data = e1 ? {4{bus.req1_data}} : {4{bus.req0_data}};
      b.src  = e1;
      mptr   = ~e1;
      if (e1) acc1++;
      else    acc0++;
      for (int i = 0; i < len; i++) begin
        b.last = (i == len - 1);
        q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    chk("drain_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int b0, a0, a1;
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req0_len   = 4'd0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.req1_len   = 4'd0;
    bus.out_ready  = 1'b1;
    do_reset();
    cycle();

    // Single req0 burst of three beats at full rate.
    b0 = beats;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h6B; bus.req0_len = 4'd3;
    cycle();
    bus.req0_valid = 1'b0;
    drain(20);
    chk("t1_beats", beats - b0, 32'd3);

    // Both requesters held valid: strict alternation starting with req0.
    do_reset();
    a0 = acc0; a1 = acc1;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h02; bus.req0_len = 4'd2;
    bus.req1_valid = 1'b1; bus.req1_data = 8'hA8; bus.req1_len = 4'd2;
    for (int i = 0; i < 12; i++) cycle();
    chk("t2_acc0", acc0 - a0, 32'd2);
    chk("t2_acc1", acc1 - a1, 32'd2);
    drain(20);

    // Backpressure mid-burst holds the beat stable.
    b0 = beats;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h7E; bus.req1_len = 4'd2;
    cycle();
    bus.req1_valid = 1'b0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    drain(20);
    chk("t3_beats", beats - b0, 32'd2);

    // Zero-length request is accepted, emits nothing, and moves the pointer.
    a0 = acc0; a1 = acc1; b0 = beats;
    bus.req0_valid = 1'b1; bus.req0_data = 8'hFC; bus.req0_len = 4'd0;
    cycle();
    bus.req0_valid = 1'b0;
    cycle();
    chk("t4_acc0", acc0 - a0, 32'd1);
    chk("t4_nobeat", beats - b0, 32'd0);
    bus.req0_valid = 1'b1; bus.req0_data = 8'h11; bus.req0_len = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h22; bus.req1_len = 4'd1;
    cycle();
    chk("t4_acc1", acc1 - a1, 32'd1);
    drain(20);

    // Reset during beat 2 of a five-beat burst.
    bus.req0_valid = 1'b1; bus.req0_data = 8'h33; bus.req0_len = 4'd5;
    bus.req1_valid = 1'b0;
    cycle();
    bus.req0_valid = 1'b0;
    cycle();
    do_reset();
    cycle();
    a0 = acc0;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h44; bus.req0_len = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h55; bus.req1_len = 4'd1;
    cycle();
    chk("t5_ptr_req0", acc0 - a0, 32'd1);
    drain(20);

    // req1 withdraws while req0 streams: never accepted.
    a1 = acc1;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h5A; bus.req0_len = 4'd4;
    cycle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h99; bus.req1_len = 4'd3;
    cycle();
    cycle();
    bus.req1_valid = 1'b0;
    drain(20);
    chk("t6_acc1", acc1 - a1, 32'd0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req0_data  = 8'($urandom);
      bus.req0_len   = 4'($urandom_range(0, 15));
      bus.req1_valid = ($urandom_range(0, 3) != 0);
      bus.req1_data  = 8'($urandom);
      bus.req1_len   = 4'($urandom_range(0, 15));
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
